fifo_rd_ctrl: RTL
=================

// Module: fifo_rd_ctrl
// PURPOSE
// - Read-domain controller for the dual-clock FIFO: owns the read pointer and all read-side status.
// - Synchronises the gray-coded write pointer into the read clock and advances the binary/gray read pointer.
// - Produces registered empty, almost_empty, fill level and an underflow pulse.
// - Replaces the purely combinational empty comparator; pairs with the write-side controller and the dual-port RAM.
// PARAMETERS
// - FIFO_DEPTH       16  entries; power of two, >= 4 (required for a valid gray wrap)
// - SYNC_STAGES      2   flop stages on the write-pointer synchroniser, >= 2
// - ALMOST_EMPTY_TH  2   almost_empty asserts when level <= this value; range 0..FIFO_DEPTH-1
// - AW (localparam)      $clog2(FIFO_DEPTH); pointers are AW+1 bits
// PORTS
// - clk           in   1     read-domain clock
// - rst           in   1     synchronous, active-high reset
// - rd_en         in   1     read request from consumer
// - wr_ptr_gray   in   AW+1  write pointer, gray, from write domain (asynchronous)
// - rd_addr       out  AW    RAM read address = rd_bin[AW-1:0]
// - rd_ptr_gray   out  AW+1  registered gray read pointer, to write-domain sync
// - rd_fire       out  1     read accepted this cycle (rd_en & ~empty)
// - empty         out  1     registered, FIFO empty as seen from the read domain
// - almost_empty  out  1     registered, level <= ALMOST_EMPTY_TH
// - rd_level      out  AW+1  registered occupancy, 0..FIFO_DEPTH
// - underflow     out  1     registered one-cycle pulse when rd_en & empty
// BEHAVIOUR
// - Reset values: rd_bin = 0, rd_ptr_gray = 0, synchroniser flops = 0, empty = 1, almost_empty = 1, rd_level = 0, underflow = 0.
// - rst has priority over everything. rd_en during rst is ignored.
// - Reset mid-stream: all state returns to reset values on the next edge. The write side is reset by its own domain.
// - Sync: wr_ptr_gray passes through SYNC_STAGES flops to give wr_gray_s; gray2bin of that gives wr_bin_s.
// - rd_fire = rd_en & ~empty (combinational from registered empty). rd_bin_next = rd_bin + rd_fire.
// - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1). rd_bin and rd_ptr_gray are registered each clock.
// - Read data latency: rd_addr is valid in the cycle of rd_fire. RAM data follows the RAM's own latency and is not handled here.
// - empty is registered as (rd_gray_next == wr_gray_s), a full AW+1-bit compare. It updates in the same edge that consumes the last word.
// - rd_level is registered as (wr_bin_s - rd_bin_next), modulo 2^(AW+1).
// - almost_empty is registered as (wr_bin_s - rd_bin_next) <= ALMOST_EMPTY_TH.
// - Write-to-visibility latency: a write-pointer change appears on empty/rd_level SYNC_STAGES+1 clk edges after it is stable at the input.
// - Status is pessimistic: stale sync can only make empty/almost_empty assert longer and rd_level read lower, never optimistic.
// - Underflow: rd_en & empty gives underflow = 1 for exactly the next cycle. The pointer does not move.
// - Repeated underflow requests give one pulse per requesting cycle.
// - Wrap-around: rd_bin wraps 2^(AW+1)-1 -> 0 naturally. The MSB distinguishes laps.
//   Level arithmetic stays correct across the wrap. rd_addr wraps FIFO_DEPTH-1 -> 0.
// - Simultaneous write arrival and last read: the read is accepted.
//   empty is computed against the wr_gray_s present that cycle; a new word shows up on later edges.
// - Back-to-back reads: one word per clock while ~empty, with no bubble.
// STRUCTURE
// - fifo_pkg holds:
//   - functions bin2gray(), gray2bin() parameterised on width;
//   - function ptr_w(depth) = $clog2(depth)+1.
//   The write-side controller shares the same package.
// - Sub-module sync_nff #(WIDTH, STAGES): plain flop chain with synchronous active-high reset.
//   Carries the synchroniser attribute for CDC signoff. It is instantiated once for wr_ptr_gray.
// - Elaboration-time check: FIFO_DEPTH is a power of two, SYNC_STAGES >= 2, and ALMOST_EMPTY_TH < FIFO_DEPTH.
// TESTING
// - Reset: hold rst for 3 clk with rd_en=1 and wr_ptr_gray=5.
//   Expect after release: empty=1, rd_level=0, rd_ptr_gray=0, underflow=0.
// - Sync latency (DEPTH=16, STAGES=2): step wr_ptr_gray 0 -> bin2gray(3).
//   Expect empty=1 for 2 edges, then empty=0, rd_level=3 and almost_empty=0 on edge 3 (TH=2).
// - Drain: with level 3, hold rd_en for 4 clk.
//   Expect rd_addr 0,1,2, empty=1 after the 3rd read, and underflow=1 exactly one cycle after the 4th request.
// - Wrap: preload rd_bin=30 and wr=bin 33 (gray), then read 3.
//   Expect rd_bin 31 -> 0 -> 1, rd_addr 14,15,0,1 sequence, and rd_level decreasing 3,2,1,0 with no glitch.
// - Full: wr_bin_s=16, rd_bin=0. Expect rd_level=16, empty=0 and almost_empty=0.
//   Read once; expect rd_level=15.
// - Mid-operation reset: assert rst at level 5 during streaming reads.
//   Expect all outputs at reset values on the next edge and no underflow pulse.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers (read and write side).
// Contents:
//   bin2gray / gray2bin : pointer code conversion; both work on any width up
//                         to 32 bits because zero-extended upper bits stay zero
//                         in either direction, so callers cast to their width.
//   ptr_w               : pointer width for a given depth (one extra lap bit).
package fifo_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    // Each binary bit is the XOR of all gray bits at or above it.
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the dual-clock FIFO.
// Signals:
//   rd_en        consumer read request
//   wr_ptr_gray  gray write pointer arriving from the write clock domain
//   rd_addr      RAM read address
//   rd_ptr_gray  registered gray read pointer toward the write domain
//   rd_fire      read accepted this cycle
//   empty, almost_empty, rd_level, underflow : registered read-side status
// Handshake: rd_en is the request and ~empty the readiness; a read transfers
// exactly in a cycle where rd_en & ~empty (reported as rd_fire), with rd_addr
// valid in that same cycle. A request while empty is dropped and flagged by a
// one-cycle underflow pulse on the following cycle.
// Modports: master = consumer / testbench side, slave = fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
  parameter int AW = 4
);
  logic          rd_en;
  logic [AW:0]   wr_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          rd_fire;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_level;
  logic          underflow;

  modport master (
    output rd_en, wr_ptr_gray,
    input  rd_addr, rd_ptr_gray, rd_fire, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    input  rd_en, wr_ptr_gray,
    output rd_addr, rd_ptr_gray, rd_fire, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/fifo_rd_ctrl_sync_nff.sv
// sync_nff: plain N-stage flop chain used as a clock-domain-crossing
// synchroniser for a gray-coded bus.
// Ports:
//   clk  in  destination clock
//   rst  in  synchronous active-high reset, clears every stage
//   d    in  WIDTH asynchronous input
//   q    out WIDTH synchronised output (last stage)
module sync_nff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain controller of the dual-clock FIFO. Owns the read
// pointer, synchronises the gray write pointer into this clock, and produces
// registered empty / almost_empty / fill level plus an underflow pulse.
// Ports:
//   clk  in  read-domain clock
//   rst  in  synchronous active-high reset (priority over everything)
//   bus  fifo_rd_ctrl_if.slave : rd_en, wr_ptr_gray in; rd_addr, rd_ptr_gray,
//        rd_fire, empty, almost_empty, rd_level, underflow out
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_ctrl_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_rd_ctrl: FIFO_DEPTH must be a power of two >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_rd_ctrl: SYNC_STAGES must be >= 2");
  end
  if ((ALMOST_EMPTY_TH < 0) || (ALMOST_EMPTY_TH >= FIFO_DEPTH)) begin : g_bad_th
    $error("fifo_rd_ctrl: ALMOST_EMPTY_TH must be in 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_ptr_gray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_rd_level;
  logic          r_underflow;

  logic [PW-1:0] w_wr_gray_s;
  logic [PW-1:0] w_wr_bin_s;
  logic          w_rd_fire;
  logic [PW-1:0] w_rd_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_level_next;

  sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.wr_ptr_gray),
    .q   (w_wr_gray_s)
  );

  assign w_wr_bin_s     = PW'(gray2bin(32'(w_wr_gray_s)));
  assign w_rd_fire      = bus.rd_en & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + {{(PW-1){1'b0}}, w_rd_fire};
  assign w_rd_gray_next = PW'(bin2gray(32'(w_rd_bin_next)));
  // Modulo 2^PW subtraction keeps the level right across pointer wrap; a stale
  // synchronised write pointer can only make it read low, never high.
  assign w_level_next   = w_wr_bin_s - w_rd_bin_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bin       <= '0;
      r_rd_ptr_gray  <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_level     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_rd_bin       <= w_rd_bin_next;
      r_rd_ptr_gray  <= w_rd_gray_next;
      // Compared against the post-read pointer so empty rises on the same
      // edge that consumes the last word.
      r_empty        <= (w_rd_gray_next == w_wr_gray_s);
      r_almost_empty <= (w_level_next <= PW'(ALMOST_EMPTY_TH));
      r_rd_level     <= w_level_next;
      r_underflow    <= bus.rd_en & r_empty;
    end
  end

  assign bus.rd_addr      = r_rd_bin[AW-1:0];
  assign bus.rd_ptr_gray  = r_rd_ptr_gray;
  assign bus.rd_fire      = w_rd_fire;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.rd_level     = r_rd_level;
  assign bus.underflow    = r_underflow;

endmodule
